// File: rtl/rx_pkg.sv
// Shared definitions for the receive buffer: default geometry and the
// controller state encoding.
package rx_pkg;

    localparam int RX_DEPTH = 8;
    localparam int RX_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_READY   = 2'd2,
        ST_DISCARD = 2'd3
    } rx_state_e;

endpackage

// File: rtl/rx_buf_mem.sv
// DEPTH x WIDTH packet storage: one write port and a registered read port.
// Only the read register is reset; the array contents are left as they are.
module rx_buf_mem
    import rx_pkg::*;
#(
    parameter int DEPTH = RX_DEPTH,
    parameter int WIDTH = RX_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rx_buf_ctrl.sv
// Receive packet buffer controller: collects bytes of one packet, holds the
// complete packet for the consumer, and throws it away on error or flush.
module rx_buf_ctrl
    import rx_pkg::*;
#(
    parameter int DEPTH = RX_DEPTH,
    parameter int WIDTH = RX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_byte_valid,
    input  logic [WIDTH-1:0]       rx_packet_data,
    input  logic                   rx_eop,
    input  logic                   rx_error,
    input  logic                   flush,
    input  logic                   rd_req,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   pkt_ready,
    output logic                   overrun,
    output logic [1:0]             state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    rx_state_e       state, state_nx;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            receiving;
    logic            discard_req;
    logic            wr_en;
    logic            drop;
    logic            rd_en;

    // Pop handshake: rd_req is honoured only in READY with data held; the
    // popped entry and rd_valid appear together one cycle later, and rd_valid
    // is a pure register so there is no rd_req -> rd_data/rd_valid path.
    assign receiving   = (state == ST_IDLE) || (state == ST_RECV);
    assign discard_req = flush || (rx_error && receiving);
    assign wr_en       = rx_byte_valid && !full && receiving && !discard_req;
    assign drop        = rx_byte_valid &&  full && receiving && !discard_req;
    assign rd_en       = rd_req && !empty && (state == ST_READY) && !flush;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign pkt_ready = (state == ST_READY);
    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        if (discard_req) begin
            state_nx = ST_DISCARD;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A byte arriving with its own end-of-packet still lands first.
                    if (rx_eop && (!empty || wr_en)) begin
                        state_nx = ST_READY;
                    end else if (rx_byte_valid) begin
                        state_nx = ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (rx_eop) begin
                        state_nx = ST_READY;
                    end
                end
                ST_READY: begin
                    if (empty || (rd_en && count == CW'(1))) begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_DISCARD: state_nx = ST_IDLE;
                default:    state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nx;
            rd_valid <= rd_en;

            if (flush) begin
                overrun <= 1'b0;
            end else if (drop) begin
                overrun <= 1'b1;
            end

            // Writes and pops live in disjoint states, so count moves by one at most.
            if (state == ST_DISCARD) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                count  <= count + CW'(1);
            end else if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
                count  <= count - CW'(1);
            end
        end
    end

    rx_buf_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (rx_packet_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_rx_buf_ctrl.sv
// Bench for rx_buf_ctrl: directed scenarios plus a randomized run, all
// checked against a queue-based packet model.
module tb_rx_buf_ctrl;
    import rx_pkg::*;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             rx_byte_valid;
    logic [WIDTH-1:0] rx_packet_data;
    logic             rx_eop;
    logic             rx_error;
    logic             flush;
    logic             rd_req;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [3:0]       count;
    logic             full;
    logic             empty;
    logic             pkt_ready;
    logic             overrun;
    logic [1:0]       state_dbg;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the buffer is a queue; phase flags describe the packet lifecycle.
    logic [WIDTH-1:0] exp_q[$];
    bit               m_recv, m_ready, m_disc, m_overrun, m_rd_valid;
    logic [WIDTH-1:0] m_rd_data;

    rx_buf_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_byte_valid  (rx_byte_valid),
        .rx_packet_data (rx_packet_data),
        .rx_eop         (rx_eop),
        .rx_error       (rx_error),
        .flush          (flush),
        .rd_req         (rd_req),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .pkt_ready      (pkt_ready),
        .overrun        (overrun),
        .state_dbg      (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] exp_state();
        if (m_disc)  return ST_DISCARD;
        if (m_ready) return ST_READY;
        if (m_recv)  return ST_RECV;
        return ST_IDLE;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_recv = 0; m_ready = 0; m_disc = 0; m_overrun = 0; m_rd_valid = 0;
        m_rd_data = '0;
    endtask

    task automatic model_update(input logic bv, input logic [WIDTH-1:0] d, input logic eop,
                                input logic err, input logic fl, input logic rr);
        m_rd_valid = 0;
        if (fl) begin
            if (m_disc) exp_q.delete();
            m_disc = 1; m_ready = 0; m_recv = 0; m_overrun = 0;
        end else if (m_disc) begin
            exp_q.delete();
            m_disc = 0;
        end else if (m_ready) begin
            if (rr && exp_q.size() > 0) begin
                m_rd_data  = exp_q.pop_front();
                m_rd_valid = 1;
            end
            if (exp_q.size() == 0) m_ready = 0;
        end else if (err) begin
            m_disc = 1; m_recv = 0;
        end else begin
            if (bv) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(d);
                else m_overrun = 1;
            end
            if (eop && (m_recv || exp_q.size() > 0)) begin
                m_ready = 1; m_recv = 0;
            end else if (bv) begin
                m_recv = 1;
            end
        end
    endtask

    task automatic step(input logic bv, input logic [WIDTH-1:0] d, input logic eop,
                        input logic err, input logic fl, input logic rr);
        rx_byte_valid = bv; rx_packet_data = d; rx_eop = eop;
        rx_error = err; flush = fl; rd_req = rr;
        @(posedge clk);
        model_update(bv, d, eop, err, fl, rr);
        #1;
        rx_byte_valid = 0; rx_eop = 0; rx_error = 0; flush = 0; rd_req = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        rx_byte_valid = 0; rx_packet_data = '0; rx_eop = 0; rx_error = 0; flush = 0; rd_req = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (count !== 4'd0)   begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_vec++; if (empty !== 1'b1)   begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
        n_vec++; if (full !== 1'b0)    begin n_err++; $display("FAIL reset_full got %b want 0", full); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        n_vec++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
        n_vec++; if (pkt_ready !== 1'b0) begin n_err++; $display("FAIL reset_pkt_ready got %b want 0", pkt_ready); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b want 0", overrun); end
        n_vec++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL reset_state got %0d want %0d", state_dbg, ST_IDLE); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_nominal();
        logic [WIDTH-1:0] bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        step(1, bytes[0], 0, 0, 0, 0);
        step(1, bytes[1], 0, 0, 0, 0);
        step(1, bytes[2], 1, 0, 0, 0);
        n_vec++; if (pkt_ready !== 1'b1) begin n_err++; $display("FAIL nominal_pkt_ready got %b want 1", pkt_ready); end
        n_vec++; if (count !== 4'd3) begin n_err++; $display("FAIL nominal_count got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, 0, 0, 1);
            n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL nominal_rd_valid[%0d] got %b want 1", i, rd_valid); end
            n_vec++; if (rd_data !== bytes[i]) begin n_err++; $display("FAIL nominal_rd_data[%0d] got %h want %h", i, rd_data, bytes[i]); end
        end
        n_vec++; if (pkt_ready !== 1'b0) begin n_err++; $display("FAIL nominal_pkt_ready_end got %b want 0", pkt_ready); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL nominal_empty got %b want 1", empty); end
        step(0, '0, 0, 0, 0, 0);
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL nominal_rd_valid_idle got %b want 0", rd_valid); end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] sent [9];
        for (int i = 0; i < 9; i++) begin
            sent[i] = WIDTH'($urandom_range(0, 255));
            step(1, sent[i], 0, 0, 0, 0);
        end
        n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL overflow_count got %0d want 8", count); end
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL overflow_full got %b want 1", full); end
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overflow_overrun got %b want 1", overrun); end
        step(0, '0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, '0, 0, 0, 0, 1);
            n_vec++; if (rd_valid !== 1'b1 || rd_data !== sent[i]) begin
                n_err++; $display("FAIL overflow_drain[%0d] got v=%b %h want v=1 %h", i, rd_valid, rd_data, sent[i]);
            end
        end
        step(0, '0, 0, 0, 0, 1);
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL overflow_ninth_absent got rd_valid=%b want 0", rd_valid); end
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overflow_sticky got %b want 1", overrun); end
        step(0, '0, 0, 0, 1, 0);
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL overflow_flush_clear got %b want 0", overrun); end
        step(0, '0, 0, 0, 0, 0);
    endtask

    task automatic test_error_discard();
        for (int i = 0; i < 4; i++) step(1, WIDTH'($urandom_range(0, 255)), 0, 0, 0, 0);
        n_vec++; if (count !== 4'd4) begin n_err++; $display("FAIL discard_count_before got %0d want 4", count); end
        step(0, '0, 0, 1, 0, 0);
        n_vec++; if (state_dbg !== ST_DISCARD) begin n_err++; $display("FAIL discard_state got %0d want %0d", state_dbg, ST_DISCARD); end
        step(0, '0, 0, 0, 0, 0);
        n_vec++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL discard_to_idle got %0d want %0d", state_dbg, ST_IDLE); end
        n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL discard_count got %0d want 0", count); end
        step(0, '0, 0, 0, 0, 1);
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL discard_no_rd got %b want 0", rd_valid); end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] want;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 6; i++) step(1, WIDTH'($urandom_range(0, 255)), (i == 5), 0, 0, 0);
            n_vec++; if (pkt_ready !== 1'b1 || count !== 4'd6) begin
                n_err++; $display("FAIL wrap_ready[%0d] got rdy=%b cnt=%0d want rdy=1 cnt=6", p, pkt_ready, count);
            end
            for (int i = 0; i < 6; i++) begin
                want = exp_q[0];
                step(0, '0, 0, 0, 0, 1);
                n_vec++; if (rd_valid !== 1'b1 || rd_data !== want) begin
                    n_err++; $display("FAIL wrap_rd[%0d.%0d] got v=%b %h want v=1 %h", p, i, rd_valid, rd_data, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 5; i++) step(1, WIDTH'($urandom_range(0, 255)), (i == 4), 0, 0, 0);
        step(0, '0, 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 1);
        #2;
        rst = 1;
        #1;
        model_reset();
        n_vec++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_err++; $display("FAIL middrain_levels got cnt=%0d e=%b f=%b want 0 1 0", count, empty, full);
        end
        n_vec++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            n_err++; $display("FAIL middrain_rd got v=%b %h want v=0 00", rd_valid, rd_data);
        end
        n_vec++; if (pkt_ready !== 1'b0 || state_dbg !== ST_IDLE) begin
            n_err++; $display("FAIL middrain_state got rdy=%b st=%0d want rdy=0 st=%0d", pkt_ready, state_dbg, ST_IDLE);
        end
        @(negedge clk);
        rst = 0;
        step(1, 8'h5a, 0, 0, 0, 0);
        n_vec++; if (state_dbg !== ST_RECV || count !== 4'd1) begin
            n_err++; $display("FAIL after_reset_first_edge got st=%0d cnt=%0d want st=%0d cnt=1", state_dbg, count, ST_RECV);
        end
        step(0, '0, 0, 0, 1, 0);
        step(0, '0, 0, 0, 0, 0);
    endtask

    task automatic test_flush_priority();
        step(1, 8'hc3, 1, 0, 1, 0);
        n_vec++; if (state_dbg !== ST_DISCARD || pkt_ready !== 1'b0) begin
            n_err++; $display("FAIL flush_state got st=%0d rdy=%b want st=%0d rdy=0", state_dbg, pkt_ready, ST_DISCARD);
        end
        n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_not_stored got cnt=%0d want 0", count); end
        step(0, '0, 0, 0, 0, 0);
        n_vec++; if (state_dbg !== ST_IDLE || count !== 4'd0) begin
            n_err++; $display("FAIL flush_to_idle got st=%0d cnt=%0d want st=%0d cnt=0", state_dbg, count, ST_IDLE);
        end
    endtask

    task automatic test_random();
        logic bv, eop, err, fl, rr;
        for (int c = 0; c < 600; c++) begin
            bv  = ($urandom_range(0, 99) < 50);
            eop = ($urandom_range(0, 99) < 10);
            err = ($urandom_range(0, 99) < 3);
            fl  = ($urandom_range(0, 99) < 2);
            rr  = ($urandom_range(0, 99) < 45);
            step(bv, WIDTH'($urandom_range(0, 255)), eop, err, fl, rr);
            n_vec++; if (count !== 4'(exp_q.size()) || full !== (exp_q.size() == DEPTH) || empty !== (exp_q.size() == 0)) begin
                n_err++; $display("FAIL rand_level[%0d] got cnt=%0d f=%b e=%b want cnt=%0d", c, count, full, empty, exp_q.size());
            end
            n_vec++; if (rd_valid !== m_rd_valid || rd_data !== m_rd_data) begin
                n_err++; $display("FAIL rand_rd[%0d] got v=%b %h want v=%b %h", c, rd_valid, rd_data, m_rd_valid, m_rd_data);
            end
            n_vec++; if (state_dbg !== exp_state() || pkt_ready !== m_ready || overrun !== m_overrun) begin
                n_err++; $display("FAIL rand_flags[%0d] got st=%0d rdy=%b ovr=%b want st=%0d rdy=%b ovr=%b",
                                  c, state_dbg, pkt_ready, overrun, exp_state(), m_ready, m_overrun);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_overflow();
        test_error_discard();
        test_wrap();
        test_reset_mid_drain();
        test_flush_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
